fetch_top: RTL and testbench

Instruction fetch stage of the etcpu 5-stage RV32I pipeline. It is the producer side of the fetch-to-decode interface: it drives if_inst, if_pc, if_branch_taken and if_branch_nt_pc into decode, and consumes intrlock_bubble (stall) and ex_branch_flush (redirect). It owns the PC register, the synchronous instruction-memory request and a direct-mapped 2-bit branch history table (BHT) predictor updated from execute.

---
 rtl/fetch_top.sv | 126 ++++++++++++
 tb/tb_fetch_top.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_top.sv
// Instruction fetch stage of the etcpu 5-stage RV32I pipeline.
// Owns the PC register, issues the synchronous instruction-memory read,
// predecodes the returned instruction and predicts branches with a
// direct-mapped table of 2-bit saturating counters trained from execute.

package fetch_pkg;
    localparam logic [31:0] BUBBLE    = 32'h0000_0013;
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;
    localparam logic [6:0]  OP_JAL    = 7'b1101111;
endpackage

module fetch_top
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          BHT_ENTRIES = 64
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        intrlock_bubble,
    input  logic        ex_branch_flush,
    input  logic [31:0] ex_redirect_pc,
    input  logic        bht_upd_vld,
    input  logic [31:0] bht_upd_pc,
    input  logic        bht_upd_taken,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    output logic        if_branch_taken,
    output logic [31:0] if_branch_nt_pc
);

    localparam int IW = $clog2(BHT_ENTRIES);

    logic [31:0]   pc_q;
    logic          vld_q;
    logic [1:0]    bht [BHT_ENTRIES];

    logic [6:0]    opcode;
    logic [31:0]   b_imm;
    logic [31:0]   j_imm;
    logic [IW-1:0] lookup_idx;
    logic [IW-1:0] upd_idx;
    logic          pred_taken;
    logic [31:0]   pred_target;
    logic [31:0]   pc_nxt;
    logic          unused_bits;

    // Redirect and update addresses only contribute their index/word bits.
    assign unused_bits = ^{ex_redirect_pc[1:0], bht_upd_pc[31:IW+2], bht_upd_pc[1:0]};

    assign if_inst         = vld_q ? imem_rdata : BUBBLE;
    assign if_pc           = pc_q;
    assign if_branch_nt_pc = pc_q + 32'd4;
    assign if_branch_taken = pred_taken;
    assign imem_addr       = pc_nxt;

    assign lookup_idx = pc_q[IW+1:2];
    assign upd_idx    = bht_upd_pc[IW+1:2];

    // Predecode the instruction on if_inst: conditional branches follow the
    // counter's MSB, JAL is always taken, everything else falls through.
    always_comb begin
        opcode      = if_inst[6:0];
        b_imm       = {{20{if_inst[31]}}, if_inst[7], if_inst[30:25], if_inst[11:8], 1'b0};
        j_imm       = {{12{if_inst[31]}}, if_inst[19:12], if_inst[20], if_inst[30:21], 1'b0};
        pred_taken  = 1'b0;
        pred_target = pc_q + 32'd4;
        if (vld_q) begin
            if (opcode == OP_BRANCH) begin
                pred_taken  = bht[lookup_idx][1];
                pred_target = pc_q + b_imm;
            end else if (opcode == OP_JAL) begin
                pred_taken  = 1'b1;
                pred_target = pc_q + j_imm;
            end
        end
    end

    // Next-PC selection: hold until the first read returns, then flush beats
    // stall, stall beats prediction, prediction beats sequential fetch.
    always_comb begin
        pc_nxt = pc_q + 32'd4;
        if (!vld_q) begin
            pc_nxt = pc_q;
        end else if (ex_branch_flush) begin
            pc_nxt = {ex_redirect_pc[31:2], 2'b00};
        end else if (intrlock_bubble) begin
            pc_nxt = pc_q;
        end else if (pred_taken) begin
            pc_nxt = pred_target;
        end
    end

    // PC register and the flag saying imem_rdata belongs to pc_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q  <= RESET_PC;
            vld_q <= 1'b0;
        end else begin
            pc_q  <= pc_nxt;
            vld_q <= 1'b1;
        end
    end

    // Branch history counters, trained by execute with saturating steps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht[i] <= 2'b01;
            end
        end else if (bht_upd_vld) begin
            if (bht_upd_taken) begin
                if (bht[upd_idx] != 2'b11) begin
                    bht[upd_idx] <= bht[upd_idx] + 2'd1;
                end
            end else begin
                if (bht[upd_idx] != 2'b00) begin
                    bht[upd_idx] <= bht[upd_idx] - 2'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_top.sv
// Directed bench for fetch_top: a vector table walks sequential fetch, JAL,
// BHT training and saturation, stall and flush-over-stall on an instance with
// RESET_PC=0, then a hand sequence checks mid-run reset on a second instance
// with RESET_PC=0x200.

module tb_fetch_top;

    localparam logic [31:0] BUBBLE = 32'h0000_0013;
    localparam logic [31:0] I00  = 32'h0010_0093;
    localparam logic [31:0] I04  = 32'h0020_0113;
    localparam logic [31:0] JAL8 = 32'h0200_00EF;
    localparam logic [31:0] I0C  = 32'h0030_0193;
    localparam logic [31:0] BEQ  = 32'hFE00_08E3;
    localparam logic [31:0] I14  = 32'h0040_0213;
    localparam logic [31:0] I18  = 32'h0050_0293;
    localparam logic [31:0] I28  = 32'h0060_0313;
    localparam logic [31:0] I2C  = 32'h0070_0393;
    localparam logic [31:0] I30  = 32'h0080_0413;
    localparam logic [31:0] I100 = 32'h0090_0493;
    localparam logic [31:0] I104 = 32'h00A0_0513;
    localparam logic [31:0] I200 = 32'h00B0_0593;
    localparam logic [31:0] FILL = 32'h0000_0033;

    typedef struct packed {
        logic        flush;
        logic [31:0] redir;
        logic        bubble;
        logic        upd_vld;
        logic [31:0] upd_pc;
        logic        upd_taken;
        logic [31:0] exp_inst;
        logic [31:0] exp_pc;
        logic        exp_taken;
        logic [31:0] exp_addr;
    } vec_t;

    localparam int NV = 22;

    logic        clk;
    logic        rst;
    logic        intrlock_bubble;
    logic        ex_branch_flush;
    logic [31:0] ex_redirect_pc;
    logic        bht_upd_vld;
    logic [31:0] bht_upd_pc;
    logic        bht_upd_taken;

    logic [31:0] d0_addr, d0_rdata, d0_inst, d0_pc, d0_nt;
    logic        d0_taken;
    logic [31:0] d1_addr, d1_rdata, d1_inst, d1_pc, d1_nt;
    logic        d1_taken;

    logic [31:0] mem [0:1023];
    vec_t        vecs [NV];
    int          checks;
    int          errors;

    fetch_top #(.RESET_PC(32'h0000_0000), .BHT_ENTRIES(64)) dut0 (
        .clk(clk), .rst(rst),
        .imem_addr(d0_addr), .imem_rdata(d0_rdata),
        .intrlock_bubble(intrlock_bubble),
        .ex_branch_flush(ex_branch_flush), .ex_redirect_pc(ex_redirect_pc),
        .bht_upd_vld(bht_upd_vld), .bht_upd_pc(bht_upd_pc), .bht_upd_taken(bht_upd_taken),
        .if_inst(d0_inst), .if_pc(d0_pc),
        .if_branch_taken(d0_taken), .if_branch_nt_pc(d0_nt)
    );

    fetch_top #(.RESET_PC(32'h0000_0200), .BHT_ENTRIES(64)) dut1 (
        .clk(clk), .rst(rst),
        .imem_addr(d1_addr), .imem_rdata(d1_rdata),
        .intrlock_bubble(intrlock_bubble),
        .ex_branch_flush(ex_branch_flush), .ex_redirect_pc(ex_redirect_pc),
        .bht_upd_vld(bht_upd_vld), .bht_upd_pc(bht_upd_pc), .bht_upd_taken(bht_upd_taken),
        .if_inst(d1_inst), .if_pc(d1_pc),
        .if_branch_taken(d1_taken), .if_branch_nt_pc(d1_nt)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read instruction memory, one read port per instance.
    always @(posedge clk) begin
        d0_rdata <= mem[d0_addr[11:2]];
        d1_rdata <= mem[d1_addr[11:2]];
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] timeout");
    end

    function automatic vec_t mk(input logic fl, input logic [31:0] rd, input logic bb,
                                input logic uv, input logic [31:0] up, input logic ut,
                                input logic [31:0] ei, input logic [31:0] ep,
                                input logic et, input logic [31:0] ea);
        vec_t v;
        v.flush = fl; v.redir = rd; v.bubble = bb;
        v.upd_vld = uv; v.upd_pc = up; v.upd_taken = ut;
        v.exp_inst = ei; v.exp_pc = ep; v.exp_taken = et; v.exp_addr = ea;
        return v;
    endfunction

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        ex_branch_flush = v.flush;
        ex_redirect_pc  = v.redir;
        intrlock_bubble = v.bubble;
        bht_upd_vld     = v.upd_vld;
        bht_upd_pc      = v.upd_pc;
        bht_upd_taken   = v.upd_taken;
    endtask

    task automatic checkOutput(input string tag, input int sel, input logic [31:0] ei,
                               input logic [31:0] ep, input logic et, input logic [31:0] ea);
        logic [31:0] ai, ap, an, aa;
        logic        at;
        if (sel == 0) begin
            ai = d0_inst; ap = d0_pc; an = d0_nt; aa = d0_addr; at = d0_taken;
        end else begin
            ai = d1_inst; ap = d1_pc; an = d1_nt; aa = d1_addr; at = d1_taken;
        end
        check_val({tag, " if_inst"}, ai, ei);
        check_val({tag, " if_pc"}, ap, ep);
        check_val({tag, " if_branch_nt_pc"}, an, ep + 32'd4);
        check_val({tag, " if_branch_taken"}, {31'd0, at}, {31'd0, et});
        check_val({tag, " imem_addr"}, aa, ea);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Main sequence: vector table on dut0, then reset corner case on dut1.
    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 1024; i++) mem[i] = FILL;
        mem[32'h000 >> 2] = I00;  mem[32'h004 >> 2] = I04;  mem[32'h008 >> 2] = JAL8;
        mem[32'h00C >> 2] = I0C;  mem[32'h010 >> 2] = BEQ;  mem[32'h014 >> 2] = I14;
        mem[32'h018 >> 2] = I18;  mem[32'h028 >> 2] = I28;  mem[32'h02C >> 2] = I2C;
        mem[32'h030 >> 2] = I30;  mem[32'h040 >> 2] = BEQ;  mem[32'h100 >> 2] = I100;
        mem[32'h104 >> 2] = I104; mem[32'h200 >> 2] = I200;

        //            fl  redir       bb  uv  upd_pc      ut  inst    pc          tk  addr
        vecs[0]  = mk(0, 32'h0,     0, 0, 32'h0,  0, BUBBLE, 32'h000, 0, 32'h000);
        vecs[1]  = mk(0, 32'h0,     0, 0, 32'h0,  0, I00,    32'h000, 0, 32'h004);
        vecs[2]  = mk(0, 32'h0,     0, 0, 32'h0,  0, I04,    32'h004, 0, 32'h008);
        vecs[3]  = mk(0, 32'h0,     0, 0, 32'h0,  0, JAL8,   32'h008, 1, 32'h028);
        vecs[4]  = mk(0, 32'h0,     0, 0, 32'h0,  0, I28,    32'h028, 0, 32'h02C);
        vecs[5]  = mk(1, 32'h10,    0, 0, 32'h0,  0, I2C,    32'h02C, 0, 32'h010);
        vecs[6]  = mk(0, 32'h0,     0, 0, 32'h0,  0, BEQ,    32'h010, 0, 32'h014);
        vecs[7]  = mk(0, 32'h0,     0, 1, 32'h10, 1, I14,    32'h014, 0, 32'h018);
        vecs[8]  = mk(1, 32'h10,    0, 1, 32'h10, 1, I18,    32'h018, 0, 32'h010);
        vecs[9]  = mk(0, 32'h0,     0, 1, 32'h10, 1, BEQ,    32'h010, 1, 32'h000);
        vecs[10] = mk(1, 32'h10,    0, 1, 32'h10, 0, I00,    32'h000, 0, 32'h010);
        vecs[11] = mk(0, 32'h0,     0, 1, 32'h10, 0, BEQ,    32'h010, 1, 32'h000);
        vecs[12] = mk(0, 32'h0,     0, 1, 32'h10, 0, I00,    32'h000, 0, 32'h004);
        vecs[13] = mk(0, 32'h0,     0, 1, 32'h10, 0, I04,    32'h004, 0, 32'h008);
        vecs[14] = mk(1, 32'h10,    0, 1, 32'h10, 1, JAL8,   32'h008, 1, 32'h010);
        vecs[15] = mk(1, 32'h4,     0, 0, 32'h0,  0, BEQ,    32'h010, 0, 32'h004);
        vecs[16] = mk(0, 32'h0,     1, 0, 32'h0,  0, I04,    32'h004, 0, 32'h004);
        vecs[17] = mk(0, 32'h0,     1, 0, 32'h0,  0, I04,    32'h004, 0, 32'h004);
        vecs[18] = mk(0, 32'h0,     0, 0, 32'h0,  0, I04,    32'h004, 0, 32'h008);
        vecs[19] = mk(1, 32'h103,   1, 0, 32'h0,  0, JAL8,   32'h008, 1, 32'h100);
        vecs[20] = mk(0, 32'h0,     0, 0, 32'h0,  0, I100,   32'h100, 0, 32'h104);
        vecs[21] = mk(0, 32'h0,     0, 0, 32'h0,  0, I104,   32'h104, 0, 32'h108);

        rst = 1'b1;
        applyStimulus(mk(0, 32'h0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 0, 32'h0));
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("vec%0d", i), 0, vecs[i].exp_inst, vecs[i].exp_pc,
                        vecs[i].exp_taken, vecs[i].exp_addr);
            next_cycle();
        end

        // Train a branch at 0x40 on dut1 and stall on it.
        applyStimulus(mk(1, 32'h40, 0, 1, 32'h40, 1, 32'h0, 32'h0, 0, 32'h0));
        next_cycle();
        applyStimulus(mk(0, 32'h0, 1, 1, 32'h40, 1, 32'h0, 32'h0, 0, 32'h0));
        #1;
        checkOutput("d1_trained_a", 1, BEQ, 32'h040, 1, 32'h040);
        next_cycle();
        applyStimulus(mk(0, 32'h0, 1, 0, 32'h0, 0, 32'h0, 32'h0, 0, 32'h0));
        #1;
        checkOutput("d1_stalled", 1, BEQ, 32'h040, 1, 32'h040);

        // Asynchronous reset while stalled.
        rst = 1'b1;
        #1;
        checkOutput("d1_in_reset", 1, BUBBLE, 32'h200, 0, 32'h200);
        checkOutput("d0_in_reset", 0, BUBBLE, 32'h000, 0, 32'h000);
        next_cycle();
        rst = 1'b0;
        applyStimulus(mk(1, 32'h40, 0, 0, 32'h0, 0, 32'h0, 32'h0, 0, 32'h0));
        #1;
        checkOutput("d1_post_reset0", 1, BUBBLE, 32'h200, 0, 32'h200);
        next_cycle();
        #1;
        checkOutput("d1_post_reset1", 1, I200, 32'h200, 0, 32'h040);
        next_cycle();
        applyStimulus(mk(0, 32'h0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 0, 32'h0));
        #1;
        checkOutput("d1_bht_reinit", 1, BEQ, 32'h040, 0, 32'h044);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
